// File: rtl/rvc_asap_5pl_fpga_in_sync.sv
// Board input conditioning for the CR memory: polarity fix, 2-flop sync,
// per-channel debounce, and registered press/change pulses.
module rvc_asap_5pl_fpga_in_sync #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
  parameter bit          SWITCH_ACTIVE_LOW = 1'b0
) (
  input  logic       Clock,
  input  logic       Rst,
  input  logic       RawButton_0,
  input  logic       RawButton_1,
  input  logic [9:0] RawSwitch,
  output logic       Button_0,
  output logic       Button_1,
  output logic [9:0] Switch,
  output logic       Button_0_Press,
  output logic       Button_1_Press,
  output logic       Switch_Chg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [11:0]   raw;
  logic [11:0]   sync1;
  logic [11:0]   sync2;
  logic [11:0]   stable;
  logic [11:0]   commit;
  logic [CW-1:0] cnt [12];
  logic          btn0_press;
  logic          btn1_press;
  logic          sw_chg;

  // Channels 0/1 are buttons, 2..11 are switch bits, all logical-high.
  assign raw = {RawSwitch ^ {10{SWITCH_ACTIVE_LOW}},
                RawButton_1 ^ BUTTON_ACTIVE_LOW,
                RawButton_0 ^ BUTTON_ACTIVE_LOW};

  always_comb begin
    commit = '0;
    for (int i = 0; i < 12; i++) begin
      commit[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      btn0_press <= 1'b0;
      btn1_press <= 1'b0;
      sw_chg     <= 1'b0;
      for (int i = 0; i < 12; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 12; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      btn0_press <= commit[0] & sync2[0];
      btn1_press <= commit[1] & sync2[1];
      sw_chg     <= |commit[11:2];
    end
  end

  assign Button_0       = stable[0];
  assign Button_1       = stable[1];
  assign Switch         = stable[11:2];
  assign Button_0_Press = btn0_press;
  assign Button_1_Press = btn1_press;
  assign Switch_Chg     = sw_chg;

endmodule

// File: tb/tb_rvc_asap_5pl_fpga_in_sync.sv
// Scoreboard bench: a DEBOUNCE_CYCLES=4 instance and a DEBOUNCE_CYCLES=1
// instance share clock and reset.
module tb_rvc_asap_5pl_fpga_in_sync;

  logic       Clock;
  logic       Rst;
  logic       rb0_a, rb1_a;
  logic [9:0] rsw_a;
  logic       b0_a, b1_a, p0_a, p1_a, chg_a;
  logic [9:0] sw_a;
  logic       rb0_b, rb1_b;
  logic [9:0] rsw_b;
  logic       b0_b, b1_b, p0_b, p1_b, chg_b;
  logic [9:0] sw_b;

  int checks = 0;
  int errors = 0;
  logic [14:0] q [$];

  rvc_asap_5pl_fpga_in_sync #(
    .DEBOUNCE_CYCLES(4),
    .BUTTON_ACTIVE_LOW(1'b1),
    .SWITCH_ACTIVE_LOW(1'b0)
  ) dut_a (
    .Clock(Clock), .Rst(Rst),
    .RawButton_0(rb0_a), .RawButton_1(rb1_a), .RawSwitch(rsw_a),
    .Button_0(b0_a), .Button_1(b1_a), .Switch(sw_a),
    .Button_0_Press(p0_a), .Button_1_Press(p1_a), .Switch_Chg(chg_a)
  );

  rvc_asap_5pl_fpga_in_sync #(
    .DEBOUNCE_CYCLES(1),
    .BUTTON_ACTIVE_LOW(1'b1),
    .SWITCH_ACTIVE_LOW(1'b0)
  ) dut_b (
    .Clock(Clock), .Rst(Rst),
    .RawButton_0(rb0_b), .RawButton_1(rb1_b), .RawSwitch(rsw_b),
    .Button_0(b0_b), .Button_1(b1_b), .Switch(sw_b),
    .Button_0_Press(p0_b), .Button_1_Press(p1_b), .Switch_Chg(chg_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [14:0] obs_a();
    return {b0_a, b1_a, sw_a, p0_a, p1_a, chg_a};
  endfunction

  function automatic logic [14:0] obs_b();
    return {b0_b, b1_b, sw_b, p0_b, p1_b, chg_b};
  endfunction

  function automatic logic [14:0] mk(logic b0, logic b1, logic [9:0] sw,
                                     logic p0, logic p1, logic chg);
    return {b0, b1, sw, p0, p1, chg};
  endfunction

  task automatic test_reset;
    logic [14:0] exp;
    Rst = 1'b0;
    rb0_a = 1'b1; rb1_a = 1'b1; rsw_a = '0;
    rb0_b = 1'b1; rb1_b = 1'b1; rsw_b = '0;
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if (obs_a() !== 15'h0) begin
      errors++;
      $display("FAIL reset_a: got %h expected %h", obs_a(), 15'h0);
    end
    checks++;
    if (obs_b() !== 15'h0) begin
      errors++;
      $display("FAIL reset_b: got %h expected %h", obs_b(), 15'h0);
    end
    Rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      q.push_back(mk(0, 0, 10'h0, 0, 0, 0));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL idle cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
  endtask

  task automatic test_press;
    logic [14:0] exp;
    for (int j = 0; j < 10; j++) begin
      rb0_a = 1'b0;
      q.push_back(mk(j >= 5, 0, 10'h0, j == 5, 0, 0));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL press cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
  endtask

  task automatic test_release;
    logic [14:0] exp;
    for (int j = 0; j < 10; j++) begin
      rb0_a = 1'b1;
      q.push_back(mk(j < 5, 0, 10'h0, 0, 0, 0));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL release cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
  endtask

  task automatic test_glitch;
    logic [14:0] exp;
    for (int j = 0; j < 12; j++) begin
      rb1_a = (j < 3) ? 1'b0 : 1'b1;
      q.push_back(mk(0, 0, 10'h0, 0, 0, 0));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL glitch3 cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
    for (int j = 0; j < 14; j++) begin
      rb1_a = (j < 4) ? 1'b0 : 1'b1;
      q.push_back(mk(0, (j >= 5) && (j <= 8), 10'h0, 0, j == 5, 0));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL glitch4 cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
  endtask

  task automatic test_switch;
    logic [14:0] exp;
    for (int j = 0; j < 10; j++) begin
      rsw_a = 10'h201;
      q.push_back(mk(0, 0, (j >= 5) ? 10'h201 : 10'h0, 0, 0, j == 5));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL switch cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
    for (int j = 0; j < 14; j++) begin
      rsw_a = 10'h201 | ((j < 6 && ((j / 2) % 2 == 0)) ? 10'h008 : 10'h000);
      q.push_back(mk(0, 0, 10'h201, 0, 0, 0));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL bounce cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [14:0] exp;
    for (int j = 0; j < 3; j++) begin
      rsw_a = 10'h020;
      q.push_back(mk(0, 0, 10'h201, 0, 0, 0));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL premid cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
    Rst = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 15'h0) begin
      errors++;
      $display("FAIL async_rst: got %h expected %h", obs_a(), 15'h0);
    end
    @(posedge Clock); #1;
    Rst = 1'b1;
    for (int j = 0; j < 10; j++) begin
      q.push_back(mk(0, 0, (j >= 5) ? 10'h020 : 10'h0, 0, 0, j == 5));
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL postrst cyc %0d: got %h expected %h", j, obs_a(), exp);
      end
    end
  endtask

  task automatic test_fast;
    logic [14:0] exp;
    logic raw_hist [20];
    logic out_now, out_prev;
    out_prev = 1'b0;
    for (int j = 0; j < 20; j++) begin
      raw_hist[j] = ((j / 3) % 2 == 0);
      rsw_b = {9'h0, raw_hist[j]};
      out_now = (j >= 2) ? raw_hist[j-2] : 1'b0;
      q.push_back(mk(0, 0, {9'h0, out_now}, 0, 0, out_now != out_prev));
      out_prev = out_now;
      @(posedge Clock); #1;
      exp = q.pop_front();
      checks++;
      if (obs_b() !== exp) begin
        errors++;
        $display("FAIL fast cyc %0d: got %h expected %h", j, obs_b(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_switch();
    test_reset_mid();
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
